encoder8to3_arb: RTL and testbench

Sequential 8-to-3 encoder that converts eight request lines back into a 3-bit code, the inverse of the team's 3-to-8 decoder. Requests are captured into a pending register, arbitrated one at a time, and presented as a registered code (x,y,z) with a valid/ack handshake. It sits between a bank of event or interrupt sources and a consumer that handles one indexed event per transaction.

---
 rtl/encoder8to3_arb.sv | 136 +++++++++++++
 tb/tb_encoder8to3_arb.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/encoder8to3_arb.sv
// encoder8to3_arb
//   Sequential 8-to-3 encoder with arbitration and a valid/ack handshake.
//   Request lines are captured into a pending register. One pending index at a
//   time is granted and presented as a registered code {x,y,z} with valid.
//   Optional feature macro: ENC_RR_EN (round-robin priority). When it is
//   undefined, the priority is fixed and the highest index wins.
// Parameters:
//   EDGE_DET  1 = capture rising edges of d, 0 = capture d levels every cycle
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   d        request lines, d[i] requests code i
//   ack      consumer accepts the presented code (ignored while valid=0)
//   x,y,z    code bits 2,1,0 (held after valid drops)
//   valid    the code is a live grant
//   pending  captured requests that have not been granted yet
//   ovf      sticky: a capture hit a bit that was already pending
module encoder8to3_arb #(
   parameter bit EDGE_DET = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] d,
   input  logic       ack,
   output logic       x,
   output logic       y,
   output logic       z,
   output logic       valid,
   output logic [7:0] pending,
   output logic       ovf
);

   localparam logic [0:0] StIdle  = 1'b0;
   localparam logic [0:0] StGrant = 1'b1;

   logic [0:0] r_state;
   logic [2:0] r_code;
   logic [7:0] r_pending;
   logic [7:0] r_d_q;
   logic       r_ovf;

   logic [7:0] w_cap;
   logic [7:0] w_clr;
   logic [7:0] w_pending_d;
   logic       w_ack_fire;
   logic       w_ovf_hit;
   logic [2:0] w_sel;
   logic       w_any;

   always_comb begin
      w_cap       = EDGE_DET ? (d & ~r_d_q) : d;
      w_ack_fire  = (r_state == StGrant) && ack;
      w_clr       = w_ack_fire ? (8'd1 << r_code) : 8'd0;
      // A capture wins over a clear on the same bit.
      w_pending_d = (r_pending & ~w_clr) | w_cap;
      w_ovf_hit   = |(w_cap & r_pending & ~w_clr);
   end

`ifdef ENC_RR_EN
   logic [2:0] r_last;
   logic [2:0] w_idx;

   // Search ascends from the index after the last grant and wraps 7 -> 0.
   always_comb begin
      w_sel = 3'd0;
      w_any = 1'b0;
      w_idx = 3'd0;
      for (int i = 1; i <= 8; i++) begin
         w_idx = r_last + 3'(i);
         if (!w_any && r_pending[w_idx]) begin
            w_sel = w_idx;
            w_any = 1'b1;
         end
      end
   end

   // Reset to 7 so the first grant after reset prefers index 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last <= 3'd7;
      end else if (w_ack_fire) begin
         r_last <= r_code;
      end
   end
`else
   // Fixed priority: later (higher) indices overwrite lower ones.
   always_comb begin
      w_sel = 3'd0;
      w_any = |r_pending;
      for (int i = 0; i < 8; i++) begin
         if (r_pending[i]) begin
            w_sel = 3'(i);
         end
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= StIdle;
         r_code    <= 3'd0;
         r_pending <= 8'd0;
         r_d_q     <= 8'd0;
         r_ovf     <= 1'b0;
      end else begin
         r_d_q     <= d;
         r_pending <= w_pending_d;
         if (w_ovf_hit) begin
            r_ovf <= 1'b1;
         end
         case (r_state)
            StIdle: begin
               // Selection looks at the registered pending set only.
               if (w_any) begin
                  r_code  <= w_sel;
                  r_state <= StGrant;
               end
            end
            StGrant: begin
               if (ack) begin
                  r_state <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign x       = r_code[2];
   assign y       = r_code[1];
   assign z       = r_code[0];
   assign valid   = (r_state == StGrant);
   assign pending = r_pending;
   assign ovf     = r_ovf;

endmodule

// File: tb/tb_encoder8to3_arb.sv
// Bench for encoder8to3_arb: an edge-capture instance (e) and a level-capture
// instance (l) share stimulus. A request-list model predicts both.
module tb_encoder8to3_arb;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] d;
   logic       ack;

   logic       x_e, y_e, z_e, valid_e, ovf_e;
   logic [7:0] pending_e;
   logic       x_l, y_l, z_l, valid_l, ovf_l;
   logic [7:0] pending_l;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   encoder8to3_arb #(.EDGE_DET(1'b1)) dut_e (
      .clk(clk), .rst(rst), .d(d), .ack(ack),
      .x(x_e), .y(y_e), .z(z_e), .valid(valid_e), .pending(pending_e), .ovf(ovf_e)
   );

   encoder8to3_arb #(.EDGE_DET(1'b0)) dut_l (
      .clk(clk), .rst(rst), .d(d), .ack(ack),
      .x(x_l), .y(y_l), .z(z_l), .valid(valid_l), .pending(pending_l), .ovf(ovf_l)
   );

   // Model state per instance: 0 = edge capture, 1 = level capture.
   int m_pend[2][8];
   int m_dprev[2][8];
   int m_ovf[2];
   int m_valid[2];
   int m_code[2];
   int m_last[2];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pick(input int m);
`ifdef ENC_RR_EN
      for (int k = 1; k <= 8; k++) begin
         if (m_pend[m][(m_last[m] + k) % 8] != 0) return (m_last[m] + k) % 8;
      end
`else
      for (int i = 7; i >= 0; i--) begin
         if (m_pend[m][i] != 0) return i;
      end
`endif
      return -1;
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < 8; i++) begin
            m_pend[m][i]  = 0;
            m_dprev[m][i] = 0;
         end
         m_ovf[m]   = 0;
         m_valid[m] = 0;
         m_code[m]  = 0;
         m_last[m]  = 7;
      end
   endtask

   task automatic model_clock(input logic [7:0] dv, input logic av);
      int cap[8];
      int clr;
      int sel;
      for (int m = 0; m < 2; m++) begin
         sel = pick(m);
         clr = (m_valid[m] != 0 && av) ? m_code[m] : -1;
         for (int i = 0; i < 8; i++) begin
            if (m == 0) cap[i] = (dv[i] && m_dprev[m][i] == 0) ? 1 : 0;
            else        cap[i] = dv[i] ? 1 : 0;
            if (cap[i] != 0 && m_pend[m][i] != 0 && i != clr) m_ovf[m] = 1;
            m_pend[m][i]  = ((m_pend[m][i] != 0 && i != clr) || cap[i] != 0) ? 1 : 0;
            m_dprev[m][i] = dv[i] ? 1 : 0;
         end
         if (m_valid[m] != 0) begin
            if (av) begin
               m_valid[m] = 0;
               m_last[m]  = m_code[m];
            end
         end else if (sel >= 0) begin
            m_valid[m] = 1;
            m_code[m]  = sel;
         end
      end
   endtask

   function automatic logic [7:0] model_pend(input int m);
      logic [7:0] v;
      for (int i = 0; i < 8; i++) v[i] = (m_pend[m][i] != 0);
      return v;
   endfunction

   task automatic compare_all();
      check_eq("valid_e",   32'(valid_e),          32'(m_valid[0]));
      check_eq("code_e",    32'({x_e, y_e, z_e}),  32'(m_code[0]));
      check_eq("pending_e", 32'(pending_e),        32'(model_pend(0)));
      check_eq("ovf_e",     32'(ovf_e),            32'(m_ovf[0]));
      check_eq("valid_l",   32'(valid_l),          32'(m_valid[1]));
      check_eq("code_l",    32'({x_l, y_l, z_l}),  32'(m_code[1]));
      check_eq("pending_l", 32'(pending_l),        32'(model_pend(1)));
      check_eq("ovf_l",     32'(ovf_l),            32'(m_ovf[1]));
   endtask

   task automatic step(input logic [7:0] dv, input logic av);
      d   = dv;
      ack = av;
      @(posedge clk);
      model_clock(dv, av);
      #1;
      compare_all();
   endtask

   // Asserts reset between edges and checks the asynchronous clear.
   task automatic do_reset();
      d   = 8'd0;
      ack = 1'b0;
      rst = 1'b1;
      #1;
      model_reset();
      check_eq("rst_valid",   32'(valid_e),         32'd0);
      check_eq("rst_code",    32'({x_e, y_e, z_e}), 32'd0);
      check_eq("rst_pending", 32'(pending_e),       32'd0);
      check_eq("rst_ovf",     32'(ovf_e),           32'd0);
      compare_all();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int exp_v[6];
      int exp_c[6];
      logic [7:0] rd;
      exp_v = '{1, 0, 1, 0, 1, 0};
      exp_c = '{7, 7, 1, 1, 0, 0};

      rst = 1'b1;
      d   = 8'd0;
      ack = 1'b0;
      model_reset();
      do_reset();

      // Single capture with ack held high.
      step(8'b0000_0100, 1'b1);
      check_eq("t1_pend", 32'(pending_e), 32'h04);
      check_eq("t1_valid_early", 32'(valid_e), 32'd0);
      step(8'd0, 1'b1);
      check_eq("t1_valid", 32'(valid_e), 32'd1);
      check_eq("t1_code", 32'({x_e, y_e, z_e}), 32'd2);
      step(8'd0, 1'b1);
      check_eq("t1_drop", 32'(valid_e), 32'd0);
      check_eq("t1_pend0", 32'(pending_e), 32'd0);
      check_eq("t1_ovf", 32'(ovf_e), 32'd0);

`ifndef ENC_RR_EN
      // Fixed priority: 7, 1, 0 with an idle cycle between grants.
      do_reset();
      step(8'b1000_0011, 1'b1);
      for (int k = 0; k < 6; k++) begin
         step(8'd0, 1'b1);
         check_eq("fp_valid", 32'(valid_e), 32'(exp_v[k]));
         check_eq("fp_code", 32'({x_e, y_e, z_e}), 32'(exp_c[k]));
      end
`endif

      // Stall on code 5; a d[2] pulse arrives during the stall.
      do_reset();
      step(8'b0010_0000, 1'b0);
      step(8'd0, 1'b0);
      for (int k = 0; k < 10; k++) begin
         step((k == 3) ? 8'b0000_0100 : 8'd0, 1'b0);
         check_eq("stall_valid", 32'(valid_e), 32'd1);
         check_eq("stall_code", 32'({x_e, y_e, z_e}), 32'd5);
      end
      step(8'd0, 1'b1);
      check_eq("stall_pend", 32'(pending_e), 32'h04);
      step(8'd0, 1'b1);
      check_eq("stall_next", 32'({valid_e, x_e, y_e, z_e}), 32'b1010);
      step(8'd0, 1'b1);

      // Overflow and capture-wins-over-clear on code 3.
      do_reset();
      step(8'b0000_1000, 1'b0);
      step(8'd0, 1'b0);
      step(8'b0000_1000, 1'b0);
      check_eq("ovf_set", 32'(ovf_e), 32'd1);
      step(8'd0, 1'b0);
      step(8'b0000_1000, 1'b1);
      check_eq("cw_pend", 32'(pending_e), 32'h08);
      check_eq("cw_drop", 32'(valid_e), 32'd0);
      step(8'd0, 1'b1);
      check_eq("cw_regrant", 32'({valid_e, x_e, y_e, z_e}), 32'b1011);
      step(8'd0, 1'b1);
      check_eq("ovf_sticky", 32'(ovf_e), 32'd1);

`ifdef ENC_RR_EN
      // Round-robin on the level-capture instance with d held at 8'hFF.
      do_reset();
      step(8'hFF, 1'b1);
      for (int k = 0; k < 18; k++) begin
         step(8'hFF, 1'b1);
         check_eq("rr_valid", 32'(valid_l), 32'((k % 2) == 0));
         if ((k % 2) == 0) check_eq("rr_code", 32'({x_l, y_l, z_l}), 32'((k / 2) % 8));
      end
`endif

      // Reset in the middle of a grant on code 6 with ovf set.
      do_reset();
      step(8'b0100_0000, 1'b0);
      step(8'd0, 1'b0);
      check_eq("mg_code", 32'({valid_e, x_e, y_e, z_e}), 32'b1110);
      step(8'b0100_0000, 1'b0);
      check_eq("mg_ovf", 32'(ovf_e), 32'd1);
      do_reset();

      // Randomized traffic with occasional resets.
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
         end else begin
            rd = ($urandom_range(0, 2) == 0) ? 8'($urandom) & 8'($urandom) : 8'd0;
            step(rd, $urandom_range(0, 3) != 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
